// File: rtl/mac_array_engine.sv
// -----------------------------------------------------------------------------
// mac_array_engine
//
// Multiply-accumulate engine for the matrix-multiply datapath. NCH parallel
// channels each accumulate K products of an unsigned DW-bit input element and
// an unsigned CW-bit coefficient. Coefficients come from a ROM with CPW
// coefficients packed per word. They are consumed MSB lane first. The
// coefficient word address runs contiguously across the NGRP groups of a pass.
// Each completed group is offered to the result collector with a valid/ready
// handshake. The end of a pass is flagged by a one-cycle done pulse.
//
// Optional feature macro: MAC_SAT_EN
//   defined   : accumulators saturate at 2^ACCW-1 and ovf is a sticky flag
//               that holds until the next start, abort or reset
//   undefined : accumulators wrap modulo 2^ACCW and ovf is tied to 0
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active-low
//   start      in   begin a pass (sampled only in IDLE)
//   abort      in   synchronous abort back to IDLE, clears all state
//   busy       out  state is not IDLE
//   coef_addr  out  registered ROM word address
//   coef_word  in   ROM data for coef_addr (combinational read)
//   x_data     in   head element of each channel, channel c at [c*DW +: DW]
//   x_valid    in   x_data valid
//   x_shift    out  x_data consumed this cycle (combinational)
//   acc_out    out  accumulators, channel c at [c*ACCW +: ACCW]
//   grp_idx    out  group being computed or presented
//   res_valid  out  acc_out holds a complete group result
//   res_ready  in   collector accepts the result
//   done       out  one-cycle pulse after the last group is accepted
//   ovf        out  sticky overflow flag (saturating build only)
//
// K must be a multiple of CPW so that every group starts on a word boundary.
// -----------------------------------------------------------------------------
module mac_array_engine #(
    parameter int NCH  = 4,
    parameter int DW   = 8,
    parameter int CW   = 7,
    parameter int CPW  = 2,
    parameter int K    = 8,
    parameter int NGRP = 8,
    parameter int ACCW = 18,
    parameter int AW   = $clog2(NGRP * K / CPW),
    localparam int GW  = (NGRP > 1) ? $clog2(NGRP) : 1,
    localparam int KW  = (K > 1) ? $clog2(K) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic [AW-1:0]         coef_addr,
    input  logic [CPW*CW-1:0]     coef_word,
    input  logic [NCH*DW-1:0]     x_data,
    input  logic                  x_valid,
    output logic                  x_shift,
    output logic [NCH*ACCW-1:0]   acc_out,
    output logic [GW-1:0]         grp_idx,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  done,
    output logic                  ovf
);

    localparam int PW = DW + CW;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [ACCW-1:0] acc     [NCH];
    logic [ACCW-1:0] acc_nxt [NCH];
    logic [PW-1:0]   prod    [NCH];
    logic [CW-1:0]   coef;
    int              lane;
    logic            last_term;
    logic            coef_step;
    logic            last_grp;

    // Accumulate one product. The sum is formed one bit wider than the
    // accumulator so that the carry out is the exact overflow indication.
`ifdef MAC_SAT_EN
    function automatic logic [ACCW-1:0] acc_add(input logic [ACCW-1:0] a,
                                                input logic [PW-1:0]   p);
        logic [ACCW:0] s;
        s = {1'b0, a} + (ACCW+1)'(p);
        return s[ACCW] ? {ACCW{1'b1}} : s[ACCW-1:0];
    endfunction

    function automatic logic acc_ovf(input logic [ACCW-1:0] a,
                                     input logic [PW-1:0]   p);
        logic [ACCW:0] s;
        s = {1'b0, a} + (ACCW+1)'(p);
        return s[ACCW];
    endfunction

    logic [NCH-1:0] ovf_step;
    logic           ovf_q;
`else
    function automatic logic [ACCW-1:0] acc_add(input logic [ACCW-1:0] a,
                                                input logic [PW-1:0]   p);
        return a + ACCW'(p);
    endfunction
`endif

    assign last_term = (k == KW'(K - 1));
    assign coef_step = ((int'(k) % CPW) == (CPW - 1));
    assign last_grp  = (grp_idx == GW'(NGRP - 1));

    // A term is consumed only when it is actually accumulated; abort wins.
    assign x_shift = (state == MAC) && x_valid && !abort;

    // Lane select and per-channel products. Lanes are consumed MSB first.
    always_comb begin
        lane = CPW - 1 - (int'(k) % CPW);
        coef = coef_word[lane*CW +: CW];
        for (int c = 0; c < NCH; c++) begin
            prod[c]    = PW'(coef) * PW'(x_data[c*DW +: DW]);
            acc_nxt[c] = acc_add(acc[c], prod[c]);
`ifdef MAC_SAT_EN
            ovf_step[c] = acc_ovf(acc[c], prod[c]);
`endif
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_pack
        assign acc_out[c*ACCW +: ACCW] = acc[c];
    end

`ifdef MAC_SAT_EN
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // Control FSM with registered outputs. Accumulators are cleared by reset
    // as well, so that no partial result survives a mid-pass reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            k         <= '0;
            grp_idx   <= '0;
            coef_addr <= '0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
`ifdef MAC_SAT_EN
            ovf_q     <= 1'b0;
`endif
        end else if (abort) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            k         <= '0;
            grp_idx   <= '0;
            coef_addr <= '0;
            for (int c = 0; c < NCH; c++) acc[c] <= '0;
`ifdef MAC_SAT_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= MAC;
                        busy      <= 1'b1;
                        k         <= '0;
                        grp_idx   <= '0;
                        coef_addr <= '0;
                        for (int c = 0; c < NCH; c++) acc[c] <= '0;
`ifdef MAC_SAT_EN
                        ovf_q     <= 1'b0;
`endif
                    end
                end

                MAC: begin
                    if (x_valid) begin
                        for (int c = 0; c < NCH; c++) acc[c] <= acc_nxt[c];
`ifdef MAC_SAT_EN
                        ovf_q <= ovf_q | (|ovf_step);
`endif
                        // The last word step of the final group rolls the
                        // address past the end; it is forced to 0 on accept.
                        if (coef_step) coef_addr <= coef_addr + 1'b1;
                        if (last_term) begin
                            // k stays at K-1 while the result is presented.
                            state     <= HOLD;
                            res_valid <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        k         <= '0;
                        for (int c = 0; c < NCH; c++) acc[c] <= '0;
                        if (last_grp) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            grp_idx   <= '0;
                            coef_addr <= '0;
                        end else begin
                            state   <= MAC;
                            grp_idx <= grp_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_array_engine.sv
// -----------------------------------------------------------------------------
// tb_mac_array_engine
//
// Directed bench for mac_array_engine. One instance uses the default 18-bit
// accumulator. A second instance with a 17-bit accumulator shares all inputs
// and shows the overflow behaviour under full-scale stimulus. The coefficient
// ROM and the input row buffer are modelled as simple pattern generators
// selected per test. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mac_array_engine;

    localparam int NCH  = 4;
    localparam int DW   = 8;
    localparam int CW   = 7;
    localparam int CPW  = 2;
    localparam int K    = 8;
    localparam int NGRP = 8;

`ifdef MAC_SAT_EN
    localparam logic [63:0] EXP_ACC17 = 64'd131071;
    localparam logic [63:0] EXP_OVF17 = 64'd1;
`else
    localparam logic [63:0] EXP_ACC17 = 64'd128008;
    localparam logic [63:0] EXP_OVF17 = 64'd0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic                x_valid = 1'b0;
    logic                res_ready = 1'b0;
    logic [CPW*CW-1:0]   coef_word;
    logic [NCH*DW-1:0]   x_data;

    logic                busy, busy17;
    logic [4:0]          coef_addr, coef_addr17;
    logic                x_shift, x_shift17;
    logic [NCH*18-1:0]   acc_out;
    logic [NCH*17-1:0]   acc_out17;
    logic [2:0]          grp_idx, grp_idx17;
    logic                res_valid, res_valid17;
    logic                done, done17;
    logic                ovf, ovf17;

    int rom_mode  = 0;
    int x_mode    = 0;
    int shift_cnt = 0;
    int base      = 0;
    int n_checks  = 0;
    int n_errors  = 0;

    mac_array_engine #(
        .NCH(NCH), .DW(DW), .CW(CW), .CPW(CPW), .K(K), .NGRP(NGRP), .ACCW(18)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
        .coef_addr(coef_addr), .coef_word(coef_word), .x_data(x_data),
        .x_valid(x_valid), .x_shift(x_shift), .acc_out(acc_out),
        .grp_idx(grp_idx), .res_valid(res_valid), .res_ready(res_ready),
        .done(done), .ovf(ovf)
    );

    mac_array_engine #(
        .NCH(NCH), .DW(DW), .CW(CW), .CPW(CPW), .K(K), .NGRP(NGRP), .ACCW(17)
    ) dut17 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy17),
        .coef_addr(coef_addr17), .coef_word(coef_word), .x_data(x_data),
        .x_valid(x_valid), .x_shift(x_shift17), .acc_out(acc_out17),
        .grp_idx(grp_idx17), .res_valid(res_valid17), .res_ready(res_ready),
        .done(done17), .ovf(ovf17)
    );

    always #5 clk = ~clk;

    // Input buffer advances on each consumed element.
    always @(posedge clk) if (x_shift) shift_cnt <= shift_cnt + 1;

    // Coefficient ROM: every word holds the same pair per mode.
    always_comb begin
        case (rom_mode)
            0:       coef_word = {7'd1, 7'd1};
            1:       coef_word = {7'd3, 7'd5};
            default: coef_word = {7'd127, 7'd127};
        endcase
    end

    // Row buffer: mode 0 feeds (idx%8+1)*(c+1) on channel c.
    always_comb begin
        int idx;
        idx = shift_cnt - base;
        for (int c = 0; c < NCH; c++) begin
            case (x_mode)
                0:       x_data[c*DW +: DW] = 8'(((idx % 8) + 1) * (c + 1));
                1:       x_data[c*DW +: DW] = 8'd10;
                default: x_data[c*DW +: DW] = 8'd255;
            endcase
        end
    end

    function automatic logic [17:0] acc18(input int c);
        return acc_out[c*18 +: 18];
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        bit first;
        bit seen;
        logic [NCH*18-1:0] snap;

        // ---------------- reset values ----------------
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_coef_addr", coef_addr, 0);
        check("rst_x_shift", x_shift, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_grp_idx", grp_idx, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b1;
        tick();

        // ---------------- basic sum ----------------
        rom_mode = 0; x_mode = 0; base = shift_cnt;
        x_valid = 1'b1; res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check("basic_busy", busy, 1);
        while (!res_valid && cyc < 40) begin tick(); cyc++; end
        check("basic_latency", cyc, 9);
        for (int c = 0; c < NCH; c++) check("basic_acc", acc18(c), 36 * (c + 1));
        check("basic_grp_idx", grp_idx, 0);
        check("basic_shift_count", shift_cnt - base, 8);
        check("basic_coef_addr", coef_addr, 4);

        // ---------------- backpressure, start while busy ----------------
        snap = acc_out;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        check("bp_res_valid", res_valid, 1);
        check("bp_acc_stable", acc_out, snap);
        check("bp_grp_idx", grp_idx, 0);
        check("bp_x_shift", x_shift, 0);
        check("bp_no_shift", shift_cnt - base, 8);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("accept_grp_idx", grp_idx, 1);
        check("accept_res_valid", res_valid, 0);
        check("accept_acc_clear", acc_out, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // ---------------- lane order ----------------
        rom_mode = 1; x_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("lane_start_acc", acc18(0), 0);
        tick();
        check("lane_msb_first", acc18(0), 30);
        check("lane_addr_hold", coef_addr, 0);
        tick();
        check("lane_pair_acc", acc18(0), 80);
        check("lane_addr_inc", coef_addr, 1);
        cyc = 3;
        while (!res_valid && cyc < 40) begin tick(); cyc++; end
        check("lane_group_acc", acc18(3), 320);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // ---------------- full scale, full pass ----------------
        rom_mode = 2; x_mode = 2; res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1; first = 1'b1;
        while (!done && cyc < 200) begin
            if (res_valid && first) begin
                first = 1'b0;
                check("full_first_valid", cyc, 9);
                check("full_acc0", acc18(0), 259080);
                check("full_acc3", acc18(3), 259080);
                check("full_ovf18", ovf, 0);
                check("ovf17_acc", acc_out17[16:0], EXP_ACC17);
                check("ovf17_flag", ovf17, EXP_OVF17);
            end
            tick();
            cyc++;
        end
        check("full_done_cycle", cyc, 73);
        check("full_addr_wrap", coef_addr, 0);
        check("full_busy_end", busy, 0);
        check("ovf17_sticky", ovf17, EXP_OVF17);
        tick();
        check("done_one_cycle", done, 0);

        // ---------------- input stall ----------------
        rom_mode = 2; x_mode = 1; res_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 40) begin
            tick();
            cyc++;
            x_valid = (cyc < 4 || cyc > 6);
            #1;
            if (cyc == 5) begin
                check("stall_x_shift", x_shift, 0);
                check("stall_acc_hold", acc18(0), 3810);
            end
        end
        check("stall_latency", cyc, 12);
        check("stall_result", acc18(0), 10160);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // ---------------- abort during group 3 ----------------
        rom_mode = 2; x_mode = 2; res_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
        while (grp_idx != 3 && cyc < 100) begin tick(); cyc++; end
        check("abort_reach_grp3", grp_idx, 3);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_acc", acc_out, 0);
        check("abort_grp_idx", grp_idx, 0);
        check("abort_coef_addr", coef_addr, 0);
        check("abort_ovf17", ovf17, 0);
        check("abort_x_shift", x_shift, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen = seen | done | res_valid;
        end
        check("abort_no_done", seen, 0);

        // ---------------- reset mid-MAC ----------------
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_reset_acc", acc18(0), 64770);
        #2;
        rst = 1'b0;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_acc", acc_out, 0);
        check("mrst_grp_idx", grp_idx, 0);
        check("mrst_coef_addr", coef_addr, 0);
        check("mrst_res_valid", res_valid, 0);
        check("mrst_x_shift", x_shift, 0);
        check("mrst_ovf17", ovf17, 0);
        rst = 1'b1;
        tick();
        check("post_reset_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_array_engine.md
# mac_array_engine

Parametrised multiply-accumulate engine for the matrix-multiply datapath. It sits between the input row buffer and the coefficient ROM on one side and the result collector on the other. It runs NCH parallel channels, each accumulating K products of an unsigned DW-bit input element and an unsigned CW-bit coefficient. Coefficients arrive CPW per ROM word. Each group result is handed off with a valid/ready handshake, and a full pass of NGRP groups is flagged with `done`.

## Interface
- NCH, 4, number of parallel channels (input rows)
- DW, 8, input element width (unsigned)
- CW, 7, coefficient width (unsigned)
- CPW, 2, coefficients packed per ROM word; K % CPW must be 0
- K, 8, products accumulated per group result
- NGRP, 8, groups per pass
- ACCW, 18, accumulator width; nominal sizing is ≥ DW+CW+clog2(K)
- AW, clog2(NGRP*K/CPW), ROM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  begin a pass; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE and clears state
- busy  out  1  high whenever the state is not IDLE
- coef_addr  out  AW  ROM word address (registered)
- coef_word  in  CPW*CW  ROM data for coef_addr; combinational read, valid in the same cycle
- x_data  in  NCH*DW  current head element of each channel, channel c at [c*DW +: DW]
- x_valid  in  1  x_data valid
- x_shift  out  1  combinational; x_data consumed this cycle, buffer advances
- acc_out  out  NCH*ACCW  accumulators, channel c at [c*ACCW +: ACCW]
- grp_idx  out  clog2(NGRP)  group currently being computed or presented
- res_valid  out  1  acc_out holds a complete group result
- res_ready  in  1  collector accepts the result
- done  out  1  one-cycle pulse after the last group is accepted
- ovf  out  1  sticky overflow flag for the pass (MAC_SAT_EN only)

## Operation
- FSM states: IDLE, MAC, HOLD.
- IDLE → MAC on start. On that transition, clear accumulators, term counter k, grp_idx, coef_addr and ovf.
- MAC step, on cycles with x_valid=1:
  - x_shift=1.
  - Lane = CPW-1-(k % CPW); lanes are consumed MSB first.
  - Update acc[c] += coef_word[lane*CW +: CW] * x_data[c*DW +: DW] for every channel c.
  - k increments.
  - coef_addr increments when k % CPW == CPW-1.
- MAC step, on cycles with x_valid=0: stall. x_shift=0 and every register holds.
- MAC → HOLD once the K-th term has been accumulated (k == K-1 with x_valid=1).
- HOLD:
  - res_valid=1; acc_out and grp_idx are stable; x_shift=0.
  - On res_valid && res_ready:
    - clear accumulators and k;
    - if grp_idx == NGRP-1: go to IDLE, wrap coef_addr to 0, pulse done on the next cycle;
    - otherwise: increment grp_idx and go to MAC.
- coef_addr runs contiguously across groups: group g uses words g*K/CPW through (g+1)*K/CPW-1.
- start while busy is ignored.
- abort in any state:
  - next cycle is IDLE with accumulators, k, grp_idx, coef_addr and ovf at 0;
  - no res_valid and no done are produced;
  - abort has priority over start and res_ready.
- Arithmetic: products are DW+CW bits, zero-extended to ACCW. Overflow handling is set by MAC_SAT_EN.

## Timing
- Reset values: busy=0, coef_addr=0, x_shift=0, acc_out=0, grp_idx=0, res_valid=0, done=0, ovf=0. FSM resets to IDLE.
- Reset asserted mid-pass takes effect immediately. No partial result survives.
- Latency with start at cycle 0 and x_valid held high:
  - MAC occupies cycles 1..K;
  - res_valid rises at cycle K+1;
  - with res_ready=1, the next group's MAC starts at cycle K+2.
- Full pass time at x_valid=1 and res_ready=1: NGRP*(K+1) cycles, then done one cycle later.
- Stalls extend latency one cycle per x_valid=0 cycle. Backpressure holds HOLD indefinitely.

## Configuration
- MAC_SAT_EN defined:
  - any accumulation whose true sum exceeds 2^ACCW-1 clamps the accumulator to 2^ACCW-1;
  - ovf is set and stays set until the next start, abort or reset.
- MAC_SAT_EN undefined:
  - accumulation wraps modulo 2^ACCW;
  - ovf is tied to 0.

## Test plan
- Basic sum (defaults): all coefficients = 1, channel 0 fed 1..8 → first res_valid at cycle 9 with acc0 = 36 and grp_idx = 0; x_shift asserted exactly 8 times.
- Lane order (defaults): coef_word = {7'd3, 7'd5}, x = 10 for two terms → partial acc = 3*10 + 5*10 = 80; coef_addr increments after the second term.
- Full scale (defaults): coef 127, x 255 on all channels → every accumulator = 259080. Over 8 groups with res_ready=1: done pulses at cycle 73 and coef_addr wraps to 0.
- Overflow (ACCW=17, full-scale stimulus):
  - with MAC_SAT_EN: acc = 131071 and ovf = 1;
  - without: acc = 128008 and ovf = 0.
- Flow control: x_valid low for 3 cycles mid-group → res_valid delayed 3 cycles, same result. res_ready low for 5 cycles → acc_out and grp_idx stable, next group not started.
- Abort/start: abort during group 3 → IDLE next cycle with all outputs 0 and no done. start while busy → ignored. Reset mid-MAC → all outputs 0 immediately.
